// File: rtl/regfile_scoreboard_if.sv
// Register-file port bundle: read ports, write/writeback ports, destination
// reservation and scoreboard visibility. master = decode/writeback, slave = regfile.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_conflict;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_clr, rsv_en, rsv_addr,
        input  rd_data, rd_busy, rsv_conflict, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, rsv_en, rsv_addr,
        output rd_data, rd_busy, rsv_conflict, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with hardwired x0 and a per-register busy
// scoreboard; optional same-cycle write-to-read forwarding.
module regfile_scoreboard #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Ascending port order lets the highest-index writer win; the reserve is
    // applied after the clears so a new producer keeps ownership.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w]) begin
                mem_d[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*XLEN +: XLEN];
                if (bus.wr_clr[w]) begin
                    busy_d[bus.wr_addr[w*AW +: AW]] = 1'b0;
                end
            end
        end
        if (bus.rsv_en) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = bus.rd_addr[gi*AW +: AW];

        // Forwarded data also means the final writeback is already here,
        // so a clearing write hides the busy bit.
        always_comb begin
            data = mem_q[addr];
            busy = busy_q[addr];
            if (BYPASS != 0 && addr != '0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == addr) begin
                        data = bus.wr_data[w*XLEN +: XLEN];
                        if (bus.wr_clr[w]) begin
                            busy = 1'b0;
                        end
                    end
                end
            end
        end

        assign bus.rd_data[gi*XLEN +: XLEN] = data;
        assign bus.rd_busy[gi]              = busy;
    end

    assign bus.rsv_conflict = bus.rsv_en && (bus.rsv_addr != '0) && busy_q[bus.rsv_addr];
    assign bus.busy_vec     = busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: dut0 = BYPASS=1/NWR=1, dut1 = BYPASS=0/NWR=2,
// both driven with identical stimulus and compared against an array model.
module tb_regfile_scoreboard;
    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_scoreboard_if #(.NWR(1)) bus0 ();
    regfile_scoreboard_if #(.NWR(2)) bus1 ();

    regfile_scoreboard #(.BYPASS(1), .NWR(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    regfile_scoreboard #(.BYPASS(0), .NWR(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus for the current cycle (write port 1 only reaches dut1)
    logic [4:0]  s_ra [2];
    logic        s_we [2];
    logic [4:0]  s_wa [2];
    logic [63:0] s_wd [2];
    logic        s_wc [2];
    logic        s_rsv;
    logic [4:0]  s_rsva;
    logic        s_rst;

    // Architectural model, one copy per DUT
    logic [63:0] m_mem  [2][32];
    logic [31:0] m_busy [2];

    localparam logic [63:0] VAL5 = 64'h1234_5678_9ABC_DEF0;

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            s_ra[i] = '0; s_we[i] = 1'b0; s_wa[i] = '0; s_wd[i] = '0; s_wc[i] = 1'b0;
        end
        s_rsv = 1'b0; s_rsva = '0; s_rst = 1'b0;
    endtask

    task automatic drive();
        reset          = s_rst;
        bus0.rd_addr   = {s_ra[1], s_ra[0]};
        bus0.wr_en     = s_we[0];
        bus0.wr_addr   = s_wa[0];
        bus0.wr_data   = s_wd[0];
        bus0.wr_clr    = s_wc[0];
        bus0.rsv_en    = s_rsv;
        bus0.rsv_addr  = s_rsva;
        bus1.rd_addr   = {s_ra[1], s_ra[0]};
        bus1.wr_en     = {s_we[1], s_we[0]};
        bus1.wr_addr   = {s_wa[1], s_wa[0]};
        bus1.wr_data   = {s_wd[1], s_wd[0]};
        bus1.wr_clr    = {s_wc[1], s_wc[0]};
        bus1.rsv_en    = s_rsv;
        bus1.rsv_addr  = s_rsva;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (s_rst) begin
                for (int r = 0; r < 32; r++) m_mem[k][r] = '0;
                m_busy[k] = '0;
            end else begin
                for (int w = 0; w < k + 1; w++)
                    if (s_we[w] && s_wa[w] != 0) m_mem[k][s_wa[w]] = s_wd[w];
                for (int w = 0; w < k + 1; w++)
                    if (s_we[w] && s_wc[w]) m_busy[k][s_wa[w]] = 1'b0;
                if (s_rsv && s_rsva != 0) m_busy[k][s_rsva] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        drive();
        #2;
    endtask

    // Only dut0 forwards, and it has a single write port
    function automatic logic [127:0] exp_rd_data(int k);
        logic [127:0] r;
        logic [63:0]  val;
        for (int p = 0; p < 2; p++) begin
            val = (s_ra[p] == 0) ? 64'd0 : m_mem[k][s_ra[p]];
            if (k == 0 && s_ra[p] != 0 && s_we[0] && s_wa[0] == s_ra[p]) val = s_wd[0];
            r[p*64 +: 64] = val;
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_rd_busy(int k);
        logic [1:0] r;
        for (int p = 0; p < 2; p++) begin
            r[p] = m_busy[k][s_ra[p]];
            if (k == 0 && s_we[0] && s_wc[0] && s_wa[0] == s_ra[p]) r[p] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic exp_conflict(int k);
        return s_rsv && (s_rsva != 0) && m_busy[k][s_rsva];
    endfunction

    task automatic get_outs(input int k, output logic [127:0] d, output logic [1:0] b,
                            output logic c, output logic [31:0] v);
        if (k == 0) begin
            d = bus0.rd_data; b = bus0.rd_busy; c = bus0.rsv_conflict; v = bus0.busy_vec;
        end else begin
            d = bus1.rd_data; b = bus1.rd_busy; c = bus1.rsv_conflict; v = bus1.busy_vec;
        end
    endtask

    task automatic test_reset();
        logic [127:0] d; logic [1:0] b; logic c; logic [31:0] v;
        for (int a = 0; a < 32; a++) begin
            idle(); s_ra[0] = 5'(a); s_ra[1] = 5'(31 - a);
            settle();
            for (int k = 0; k < 2; k++) begin
                get_outs(k, d, b, c, v);
                n_tests++;
                if (d !== '0) begin n_fail++; $display("FAIL reset_rd_data dut%0d x%0d got %h expected 0", k, a, d); end
                n_tests++;
                if (v !== '0) begin n_fail++; $display("FAIL reset_busy_vec dut%0d got %h expected 0", k, v); end
                n_tests++;
                if (b !== 2'b00 || c !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d got rd_busy=%b conflict=%b expected 00/0", k, b, c); end
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic [127:0] d; logic [1:0] b; logic c; logic [31:0] v;
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd5; s_wd[0] = VAL5; s_ra[0] = 5'd5;
        settle();
        get_outs(0, d, b, c, v);
        n_tests++;
        if (d[63:0] !== VAL5) begin n_fail++; $display("FAIL bypass_same_cycle dut0 got %h expected %h", d[63:0], VAL5); end
        get_outs(1, d, b, c, v);
        n_tests++;
        if (d[63:0] !== 64'd0) begin n_fail++; $display("FAIL nobypass_same_cycle dut1 got %h expected 0", d[63:0]); end
        tick();
        idle(); s_ra[0] = 5'd5;
        settle();
        for (int k = 0; k < 2; k++) begin
            get_outs(k, d, b, c, v);
            n_tests++;
            if (d[63:0] !== VAL5) begin n_fail++; $display("FAIL write_stored dut%0d got %h expected %h", k, d[63:0], VAL5); end
        end
        tick();
    endtask

    task automatic test_zero();
        logic [127:0] d; logic [1:0] b; logic c; logic [31:0] v;
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd0; s_wd[0] = 64'hFFFF; s_rsv = 1'b1; s_rsva = 5'd0;
        settle();
        for (int k = 0; k < 2; k++) begin
            get_outs(k, d, b, c, v);
            n_tests++;
            if (c !== 1'b0 || d[63:0] !== 64'd0) begin n_fail++; $display("FAIL x0_write_cycle dut%0d got conflict=%b data=%h expected 0/0", k, c, d[63:0]); end
        end
        tick();
        idle();
        settle();
        for (int k = 0; k < 2; k++) begin
            get_outs(k, d, b, c, v);
            n_tests++;
            if (v !== '0 || d[63:0] !== 64'd0) begin n_fail++; $display("FAIL x0_after dut%0d got busy_vec=%h data=%h expected 0/0", k, v, d[63:0]); end
        end
        tick();
    endtask

    task automatic test_reserve();
        logic [127:0] d; logic [1:0] b; logic c; logic [31:0] v;
        idle(); s_rsv = 1'b1; s_rsva = 5'd7; s_ra[0] = 5'd7;
        settle();
        for (int k = 0; k < 2; k++) begin
            get_outs(k, d, b, c, v);
            n_tests++;
            if (b !== 2'b00 || c !== 1'b0) begin n_fail++; $display("FAIL rsv_same_cycle dut%0d got rd_busy=%b conflict=%b expected 00/0", k, b, c); end
        end
        tick();
        idle(); s_rsv = 1'b1; s_rsva = 5'd7; s_ra[0] = 5'd7; s_ra[1] = 5'd7;
        settle();
        for (int k = 0; k < 2; k++) begin
            get_outs(k, d, b, c, v);
            n_tests++;
            if (b !== 2'b11 || c !== 1'b1) begin n_fail++; $display("FAIL rsv_waw dut%0d got rd_busy=%b conflict=%b expected 11/1", k, b, c); end
        end
        tick();
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd7; s_wd[0] = 64'd42; s_wc[0] = 1'b1; s_ra[0] = 5'd7;
        settle();
        get_outs(0, d, b, c, v);
        n_tests++;
        if (b[0] !== 1'b0 || d[63:0] !== 64'd42) begin n_fail++; $display("FAIL wb_bypass dut0 got rd_busy=%b data=%0d expected 0/42", b[0], d[63:0]); end
        get_outs(1, d, b, c, v);
        n_tests++;
        if (b[0] !== 1'b1 || d[63:0] !== 64'd0) begin n_fail++; $display("FAIL wb_nobypass dut1 got rd_busy=%b data=%0d expected 1/0", b[0], d[63:0]); end
        tick();
        idle(); s_ra[0] = 5'd7;
        settle();
        for (int k = 0; k < 2; k++) begin
            get_outs(k, d, b, c, v);
            n_tests++;
            if (v[7] !== 1'b0 || b[0] !== 1'b0 || d[63:0] !== 64'd42) begin n_fail++; $display("FAIL wb_after dut%0d got busy7=%b rd_busy=%b data=%0d expected 0/0/42", k, v[7], b[0], d[63:0]); end
        end
        tick();
    endtask

    task automatic test_rsv_clr_same();
        logic [127:0] d; logic [1:0] b; logic c; logic [31:0] v;
        idle(); s_rsv = 1'b1; s_rsva = 5'd9; s_we[0] = 1'b1; s_wa[0] = 5'd9; s_wd[0] = 64'd7; s_wc[0] = 1'b1;
        settle();
        tick();
        idle(); s_ra[0] = 5'd9;
        settle();
        for (int k = 0; k < 2; k++) begin
            get_outs(k, d, b, c, v);
            n_tests++;
            if (v[9] !== 1'b1 || b[0] !== 1'b1 || d[63:0] !== 64'd7) begin n_fail++; $display("FAIL rsv_clr_same dut%0d got busy9=%b rd_busy=%b data=%0d expected 1/1/7", k, v[9], b[0], d[63:0]); end
        end
        tick();
    endtask

    task automatic test_multi_write();
        logic [127:0] d; logic [1:0] b; logic c; logic [31:0] v;
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd3; s_wd[0] = 64'd11;
        s_we[1] = 1'b1; s_wa[1] = 5'd3; s_wd[1] = 64'd22; s_rsv = 1'b1; s_rsva = 5'd3;
        settle();
        tick();
        idle(); s_ra[0] = 5'd3;
        settle();
        get_outs(1, d, b, c, v);
        n_tests++;
        if (d[63:0] !== 64'd22 || v[3] !== 1'b1) begin n_fail++; $display("FAIL dual_write dut1 got data=%0d busy3=%b expected 22/1", d[63:0], v[3]); end
        get_outs(0, d, b, c, v);
        n_tests++;
        if (d[63:0] !== 64'd11 || v[3] !== 1'b1) begin n_fail++; $display("FAIL single_write dut0 got data=%0d busy3=%b expected 11/1", d[63:0], v[3]); end
        tick();
        idle(); s_rst = 1'b1; s_we[0] = 1'b1; s_wa[0] = 5'd3; s_wd[0] = 64'd99; s_rsv = 1'b1; s_rsva = 5'd4;
        settle();
        tick();
        idle(); s_ra[0] = 5'd3; s_ra[1] = 5'd5;
        settle();
        for (int k = 0; k < 2; k++) begin
            get_outs(k, d, b, c, v);
            n_tests++;
            if (d !== '0 || v !== '0) begin n_fail++; $display("FAIL reset_busy_reg dut%0d got data=%h busy_vec=%h expected 0/0", k, d, v); end
        end
        tick();
    endtask

    task automatic test_random();
        logic [127:0] d; logic [1:0] b; logic c; logic [31:0] v;
        logic [127:0] e_d; logic [1:0] e_b; logic e_c;
        for (int n = 0; n < 400; n++) begin
            idle();
            s_rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 2; i++) begin
                s_ra[i] = 5'($urandom_range(0, 9));
                s_we[i] = 1'($urandom_range(0, 1));
                s_wa[i] = 5'($urandom_range(0, 7));
                s_wd[i] = {$urandom, $urandom};
                s_wc[i] = 1'($urandom_range(0, 1));
            end
            s_rsv  = 1'($urandom_range(0, 1));
            s_rsva = 5'($urandom_range(0, 7));
            settle();
            if (!s_rst) begin
                for (int k = 0; k < 2; k++) begin
                    get_outs(k, d, b, c, v);
                    e_d = exp_rd_data(k); e_b = exp_rd_busy(k); e_c = exp_conflict(k);
                    n_tests++;
                    if (d !== e_d) begin n_fail++; $display("FAIL rand_rd_data dut%0d cyc%0d got %h expected %h", k, n, d, e_d); end
                    n_tests++;
                    if (b !== e_b) begin n_fail++; $display("FAIL rand_rd_busy dut%0d cyc%0d got %b expected %b", k, n, b, e_b); end
                    n_tests++;
                    if (c !== e_c) begin n_fail++; $display("FAIL rand_conflict dut%0d cyc%0d got %b expected %b", k, n, c, e_c); end
                    n_tests++;
                    if (v !== m_busy[k]) begin n_fail++; $display("FAIL rand_busy_vec dut%0d cyc%0d got %h expected %h", k, n, v, m_busy[k]); end
                end
            end
            tick();
        end
    endtask

    initial begin
        idle(); s_rst = 1'b1;
        drive();
        tick();
        tick();
        test_reset();
        test_bypass();
        test_zero();
        test_reserve();
        test_rsv_clr_same();
        test_multi_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-port integer register file, the next generation of the core's register file.
- Configurable data width, register count, read-port count and write-port count.
- Write-to-read bypass is optional.
- Has a hardwired zero register and per-register busy bits (scoreboard). Decode reserves a destination register at issue; writeback clears the reservation. Decode stalls on RAW hazards from the per-port busy flags.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see only stored contents.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- rd_addr  in  NRD*AW  read addresses; port p uses bits [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data, combinational
- rd_busy  out  NRD  1 = register addressed by port p has a pending reservation
- wr_en  in  NWR  write enable per write port
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- wr_clr  in  NWR  1 = this write also clears the busy bit of wr_addr (final writeback)
- rsv_en  in  1  reserve request for a destination register
- rsv_addr  in  AW  register to reserve
- rsv_conflict  out  1  combinational; rsv_en=1 and rsv_addr already busy (WAW)
- busy_vec  out  NREGS  full scoreboard, for debug and commit logic

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
- Reset effect: at the clocking edge with reset=1, all NREGS registers become 0 and all busy bits clear. wr_en and rsv_en in that cycle are ignored.
- After reset, rd_data=0, rd_busy=0, busy_vec=0, rsv_conflict=0 until a reservation is made.
- Register 0:
  - always reads 0;
  - writes to it are dropped;
  - it is never busy;
  - rsv_en with rsv_addr=0 is a no-op and never raises rsv_conflict.
- Write timing: with wr_en[w]=1 at edge N, wr_data[w] is stored at edge N.
- Read timing: reads are combinational from the array.
  - BYPASS=1: a read in the same cycle as a write to the same non-zero address returns wr_data.
  - BYPASS=0: that read returns the old value and the new value is visible from cycle N+1.
- Multiple write ports to the same address in one cycle: the highest-index port wins, for both storage and bypass. No error flag.
- Busy bit update per edge, priority high to low:
  1. reset clears all busy bits;
  2. rsv_en sets busy[rsv_addr] (rsv_addr≠0);
  3. wr_en[w] & wr_clr[w] clears busy[wr_addr[w]].
  Consequence: a reserve and a clear of the same register in the same cycle leaves it busy (the new producer owns it).
- wr_en without wr_clr writes the data and leaves the busy bit unchanged (partial/early result).
- rd_busy[p] = busy[rd_addr[p]] from the state before this edge.
  - With BYPASS=1, a same-cycle wr_en&wr_clr to that address drops rd_busy[p] to 0, since the data is forwarded.
  - A same-cycle reserve does not raise rd_busy (the reservation takes effect at the edge).
- rsv_conflict only reports the WAW condition. A reservation with rsv_en=1 proceeds even when rsv_conflict=1; decode is required to stall instead.
- Clearing a register that is not busy is legal and has no effect.
- All outputs are free of X after the first reset edge, for any in-range input.

Test Plan:
- Reset, then read x0..x31 on both ports -> every rd_data=0, busy_vec=0.
- Write x5=0x1234_5678_9ABC_DEF0 with BYPASS=1 and rd_addr[0]=5 in the same cycle -> rd_data[0]=0x1234_5678_9ABC_DEF0 in that cycle and thereafter. Repeat with BYPASS=0 -> old value 0 in that cycle, new value from the next cycle.
- Write x0=0xFFFF and reserve x0 -> x0 reads 0, busy_vec[0]=0, rsv_conflict=0.
- Reserve x7 -> next cycle rd_busy=1 on a port reading x7 and rsv_conflict=1 on a second reserve of x7. Writeback with wr_en=1, wr_clr=1, data 42 -> BYPASS=1 gives rd_busy=0 and rd_data=42 in the same cycle; busy_vec[7]=0 after the edge.
- Same cycle: reserve x9 and wr_clr writeback to x9 (data 7) -> x9=7 and busy_vec[9]=1 after the edge.
- NWR=2: both ports write x3 with 11 and 22 -> x3=22. Assert reset while x3 is busy -> next cycle x3=0 and busy_vec=0.
